// File: rtl/axis_tiny_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: one packet per grant, grant held until tlast,
// with a single registered output stage that can load and drain in the same cycle.
module axis_tiny_rr_arbiter #(
  parameter int BUS_WIDTH  = 1,
  parameter int NUM_PORTS  = 4,
  parameter int DEST_WIDTH = 4
) (
  input  logic                              aclk,
  input  logic                              arst,
  input  logic [NUM_PORTS*BUS_WIDTH*8-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  output logic [BUS_WIDTH*8-1:0]            m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest,
  input  logic                              m_axis_tready
);

  localparam int DW    = BUS_WIDTH * 8;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;

  logic [DW-1:0]         data_q;
  logic                  valid_q;
  logic                  last_q;
  logic [DEST_WIDTH-1:0] dest_q;

  logic [NUM_PORTS-1:0] ready;
  logic                 out_free;
  logic                 accept;
  logic                 grant_last;
  logic [DW-1:0]        grant_data;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  int                   scan_idx;

  // The output slot is free when empty or when its beat leaves this cycle,
  // which is what lets a new beat load while the old one drains.
  assign out_free   = ~valid_q | m_axis_tready;
  assign grant_data = s_axis_tdata[int'(grant_q)*DW +: DW];
  assign grant_last = s_axis_tlast[grant_q];
  assign accept     = (state_q == LOCKED) & s_axis_tvalid[grant_q] & out_free;

  // First valid port scanning ptr, ptr+1, ... modulo NUM_PORTS.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!pick_found && s_axis_tvalid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (arst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          grant_d = pick_idx;
        end
      end
      LOCKED: begin
        // Release on the accepted tlast beat; the output register may still hold data.
        if (accept && grant_last) begin
          state_d = IDLE;
          ptr_d   = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: only the granted port may see ready.
  always_comb begin
    ready = '0;
    if (state_q == LOCKED) ready[grant_q] = out_free;
  end

  // Output register stage.
  always_ff @(posedge aclk) begin
    if (arst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      dest_q  <= '0;
    end else if (accept) begin
      data_q  <= grant_data;
      valid_q <= 1'b1;
      last_q  <= grant_last;
      dest_q  <= DEST_WIDTH'(grant_q);
    end else if (valid_q && m_axis_tready) begin
      valid_q <= 1'b0;
    end
  end

  assign s_axis_tready = ready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tdest  = dest_q;

endmodule

// File: doc/axis_tiny_rr_arbiter.md
Name: axis_tiny_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXIS output between NUM_PORTS AXIS slave requesters, one packet at a time.
- Grant is locked from the first beat to the tlast beat, then rotates.
- Output is a single registered stage, tiny-FIFO depth, so it drops in directly ahead of axis_tiny_fifo or any downstream AXIS sink.

Parameters:
- BUS_WIDTH, 1: tdata width in bytes.
- NUM_PORTS, 4: number of slave requesters (2..16).
- DEST_WIDTH, 4: width of m_axis_tdest. Must satisfy 2^DEST_WIDTH >= NUM_PORTS.

Ports:
- aclk  in  1  AXIS clock. The block runs on one clock only.
- arst  in  1  Reset, synchronous and active-high.
- s_axis_tdata  in  NUM_PORTS*BUS_WIDTH*8  Flattened slave data; port i occupies bits [i*BUS_WIDTH*8 +: BUS_WIDTH*8].
- s_axis_tvalid  in  NUM_PORTS  Per-port valid.
- s_axis_tlast  in  NUM_PORTS  Per-port end of packet.
- s_axis_tready  out  NUM_PORTS  Per-port ready; one-hot or zero.
- m_axis_tdata  out  BUS_WIDTH*8  Registered output data.
- m_axis_tvalid  out  1  Registered output valid.
- m_axis_tlast  out  1  Registered output last.
- m_axis_tdest  out  DEST_WIDTH  Index of the source port of the current beat.
- m_axis_tready  in  1  Downstream ready.

Behaviour:
- Reset (arst high at a rising aclk edge):
  - m_axis_tvalid/tdata/tlast/tdest = 0; s_axis_tready = 0.
  - State = IDLE; priority pointer = 0; grant = 0.
  - Any beat held in the output register is discarded. A packet in progress is abandoned.
- State IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid is set, grant goes to the first valid port found scanning ptr, ptr+1, ..., wrapping modulo NUM_PORTS. State becomes LOCKED on the next edge.
  - If no port is valid, stay in IDLE.
- State LOCKED:
  - s_axis_tready[grant] = (~m_axis_tvalid | m_axis_tready). All other ready bits = 0.
  - Ready is combinational from the register status, so the block sustains full throughput.
  - Slave beat accepted (valid & ready on the grant port): the output register loads tdata/tlast of that port, tdest = grant, m_axis_tvalid = 1.
  - Output register drained (m_axis_tvalid & m_axis_tready) with no new load: m_axis_tvalid = 0.
  - Load and drain in the same cycle: the register takes the new beat and valid stays 1.
- Leaving LOCKED:
  - Triggered when the accepted slave beat has tlast = 1.
  - State returns to IDLE and ptr = (grant+1) mod NUM_PORTS.
  - This does not wait for the output register to drain. Arbitration for the next packet overlaps the drain.
- Latency:
  - Request seen in IDLE at cycle 0 → grant/ready at cycle 1 → first m_axis_tvalid at cycle 2.
  - Minimum gap between packets is 1 idle slave-side cycle (the IDLE arbitration cycle).
- Boundary conditions:
  - A single-beat packet (tlast on the first beat) is legal and rotates the pointer.
  - A granted port that drops tvalid mid-packet keeps the grant. The block waits indefinitely; there is no timeout.
  - A port that asserts tvalid while another port is locked is not served until the lock releases.
  - Rotation is fair: with all ports continuously requesting, grants follow ptr order 0,1,...,N-1,0.
  - m_axis_tvalid, once set, holds with stable tdata/tlast/tdest until m_axis_tready (AXIS rule).
  - Pointer wrap: grant = NUM_PORTS-1 gives ptr = 0.

Test Plan:
- Reset check: after reset, all outputs = 0. Then port 2 sends a 3-beat packet 0x10,0x11,0x12 with tlast on 0x12 and m_axis_tready = 1. Required: output 0x10,0x11,0x12, tdest = 2, tlast on the third beat, first m_axis_tvalid exactly 2 cycles after s_axis_tvalid[2] is first high in IDLE.
- Fairness: all 4 ports continuously send 2-beat packets with data = port*0x10 + beat. Required: tdest sequence 0,1,2,3,0,1 and no interleaving of beats within a packet.
- Backpressure: m_axis_tready is randomized (~50%) during a 16-beat packet from port 1 with data 0x00..0x0F. Required: all 16 beats arrive in order and unduplicated, and tdata is stable while valid & ~ready.
- Lock hold: port 0 starts a 4-beat packet and deasserts tvalid for 5 cycles after beat 2, while port 3 is valid throughout. Required: s_axis_tready[3] = 0 until port 0's tlast is accepted, then port 3 is granted next (ptr = 1, port 1 not valid, port 3 selected).
- Reset mid-packet: assert arst during beat 2 of a port-1 packet while m_axis_tvalid = 1. Required: next cycle m_axis_tvalid = 0, ptr = 0, and a subsequent request from ports 0 and 1 together grants port 0 first.
- Single-beat packets: each port sends single-beat packets (tlast = 1) back-to-back with m_axis_tready = 1. Required: tdest rotates 0,1,2,3, and each packet takes 2 slave-side cycles (IDLE + LOCKED).
